// File: rtl/test_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : test_counter_pkg
//  Description : Shared types, word indices and a saturating increment for
//                the coincidence counter.
//  Revision    : 1.0  initial release
// ============================================================================
package test_counter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GATE = 1'b1
  } gate_state_t;

  localparam logic [1:0] W_A = 2'd0;
  localparam logic [1:0] W_B = 2'd1;
  localparam logic [1:0] W_C = 2'd2;

  // Callers zero-extend into this width and truncate the result back, so
  // any counter up to 64 bits can share one helper.
  localparam int SAT_MAX_WIDTH = 64;
  typedef logic [SAT_MAX_WIDTH-1:0] sat_word_t;

  function automatic sat_word_t sat_inc(input sat_word_t value,
                                        input sat_word_t max_value,
                                        input logic      en);
    sat_word_t result;
    result = value;
    if (en && (value != max_value)) begin
      result = value + sat_word_t'(1);
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/test_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : test_rise_detect
//  Description : Per-bit rising-edge detector on the 2-bit detector flags.
//  Revision    : 1.0  initial release
// ============================================================================
module test_rise_detect (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] test_data,
  output logic [1:0] rise
);

  logic [1:0] prev_q;
  logic [1:0] prev_d;

  always_comb begin
    prev_d = test_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prev_q <= 2'b00;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = test_data & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/test_coincidence_counter.sv
`default_nettype none
// ============================================================================
//  Module      : test_coincidence_counter
//  Description : Gated edge/coincidence counter; each completed gate is
//                shipped as a 3-word AXI4-Stream frame.
//  Revision    : 1.0  initial release
// ============================================================================
module test_coincidence_counter
  import test_counter_pkg::*;
#(
  parameter int CNTR_WIDTH = 32,
  parameter int LOST_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [1:0]            test_data,
  input  logic                  run,
  input  logic [CNTR_WIDTH-1:0] cfg_data,
  output logic [CNTR_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [LOST_WIDTH-1:0] sts_lost
);

  localparam logic [CNTR_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [LOST_WIDTH-1:0] LOST_MAX = '1;

  logic [1:0] rise;

  test_rise_detect u_rise_detect (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .test_data (test_data),
    .rise      (rise)
  );

  gate_state_t           state_q, state_d;
  logic [CNTR_WIDTH-1:0] len_q, len_d;
  logic [CNTR_WIDTH-1:0] timer_q, timer_d;
  logic [CNTR_WIDTH-1:0] cnt_a_q, cnt_a_d;
  logic [CNTR_WIDTH-1:0] cnt_b_q, cnt_b_d;
  logic [CNTR_WIDTH-1:0] cnt_c_q, cnt_c_d;

  logic [CNTR_WIDTH-1:0] cnt_a_inc, cnt_b_inc, cnt_c_inc;
  logic [CNTR_WIDTH-1:0] len_last;
  logic                  cfg_nonzero;
  logic                  gate_terminal;

  assign cnt_a_inc = CNTR_WIDTH'(sat_inc(sat_word_t'(cnt_a_q), sat_word_t'(CNT_MAX), rise[0]));
  assign cnt_b_inc = CNTR_WIDTH'(sat_inc(sat_word_t'(cnt_b_q), sat_word_t'(CNT_MAX), rise[1]));
  assign cnt_c_inc = CNTR_WIDTH'(sat_inc(sat_word_t'(cnt_c_q), sat_word_t'(CNT_MAX), &rise));

  assign len_last      = len_q - CNTR_WIDTH'(1);
  assign cfg_nonzero   = (cfg_data != '0);
  // The terminal cycle completes the gate even if run falls in that cycle.
  assign gate_terminal = (state_q == GATE) && (timer_q == len_last);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    timer_d = timer_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    cnt_c_d = cnt_c_q;
    if (state_q == IDLE) begin
      if (run && cfg_nonzero) begin
        state_d = GATE;
        len_d   = cfg_data;
        timer_d = '0;
        cnt_a_d = '0;
        cnt_b_d = '0;
        cnt_c_d = '0;
      end
    end else if (gate_terminal) begin
      timer_d = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      cnt_c_d = '0;
      if (run && cfg_nonzero) begin
        len_d = cfg_data;
      end else begin
        state_d = IDLE;
      end
    end else if (!run) begin
      state_d = IDLE;
      timer_d = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      cnt_c_d = '0;
    end else begin
      timer_d = timer_q + CNTR_WIDTH'(1);
      cnt_a_d = cnt_a_inc;
      cnt_b_d = cnt_b_inc;
      cnt_c_d = cnt_c_inc;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      len_q   <= '0;
      timer_q <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
    end
  end

  logic                  busy_q, busy_d;
  logic [1:0]            idx_q, idx_d;
  logic [CNTR_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic [CNTR_WIDTH-1:0] snap_b_q, snap_b_d;
  logic [CNTR_WIDTH-1:0] snap_c_q, snap_c_d;
  logic [LOST_WIDTH-1:0] lost_q, lost_d;

  // Word A is loaded straight into the output register; B and C wait in
  // the snapshot registers until their turn.
  always_comb begin
    busy_d   = busy_q;
    idx_d    = idx_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    snap_b_d = snap_b_q;
    snap_c_d = snap_c_q;
    lost_d   = lost_q;
    if (busy_q) begin
      if (m_axis_tready) begin
        case (idx_q)
          W_A: begin
            tdata_d = snap_b_q;
            idx_d   = W_B;
          end
          W_B: begin
            tdata_d = snap_c_q;
            tlast_d = 1'b1;
            idx_d   = W_C;
          end
          default: begin
            busy_d  = 1'b0;
            tlast_d = 1'b0;
            idx_d   = W_A;
          end
        endcase
      end
      if (gate_terminal) begin
        lost_d = LOST_WIDTH'(sat_inc(sat_word_t'(lost_q), sat_word_t'(LOST_MAX), 1'b1));
      end
    end else if (gate_terminal) begin
      busy_d   = 1'b1;
      idx_d    = W_A;
      tdata_d  = cnt_a_inc;
      tlast_d  = 1'b0;
      snap_b_d = cnt_b_inc;
      snap_c_d = cnt_c_inc;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy_q   <= 1'b0;
      idx_q    <= W_A;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      snap_b_q <= '0;
      snap_c_q <= '0;
      lost_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      snap_b_q <= snap_b_d;
      snap_c_q <= snap_c_d;
      lost_q   <= lost_d;
    end
  end

  assign m_axis_tvalid = busy_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign sts_lost      = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_test_coincidence_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_coincidence_counter
//  Description : Self-checking bench for test_coincidence_counter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_test_coincidence_counter;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [1:0]  td = 2'b00;
  logic        run = 1'b0;
  logic [31:0] cfg = '0;
  logic        tready = 1'b1;
  logic [31:0] tdata;
  logic        tvalid, tlast;
  logic [15:0] lost;

  logic [3:0]  cfg4;
  logic [3:0]  tdata4;
  logic        tvalid4, tlast4;
  logic [15:0] lost4;

  assign cfg4 = cfg[3:0];

  always #5 clk = ~clk;

  test_coincidence_counter #(.CNTR_WIDTH(32), .LOST_WIDTH(16)) dut (
    .aclk(clk), .aresetn(aresetn), .test_data(td), .run(run), .cfg_data(cfg),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .sts_lost(lost)
  );

  test_coincidence_counter #(.CNTR_WIDTH(4), .LOST_WIDTH(16)) dut4 (
    .aclk(clk), .aresetn(aresetn), .test_data(td), .run(run), .cfg_data(cfg4),
    .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4), .m_axis_tready(tready),
    .m_axis_tlast(tlast4), .sts_lost(lost4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: gate progress as plain integers, sender as a word queue.
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;
  localparam longint LMAX = 65535;
  bit [1:0] m_prev;
  bit       m_active;
  longint   m_len, m_pos, m_ca, m_cb, m_cc, m_lost;
  longint   fq[$];
  longint   got[$];
  longint   got4[$];

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_prev = 2'b00; m_active = 1'b0; m_len = 0; m_pos = 0;
    m_ca = 0; m_cb = 0; m_cc = 0; m_lost = 0;
    fq.delete();
  endtask

  task automatic model_step();
    bit [1:0] r;
    bit       was_busy;
    r        = td & ~m_prev;
    was_busy = (fq.size() != 0);
    if (was_busy && tready) void'(fq.pop_front());
    if (!m_active) begin
      if (run && cfg != 0) begin
        m_active = 1'b1; m_len = cfg; m_pos = 0; m_ca = 0; m_cb = 0; m_cc = 0;
      end
    end else begin
      m_pos++;
      m_ca = sat(m_ca + r[0], CMAX);
      m_cb = sat(m_cb + r[1], CMAX);
      m_cc = sat(m_cc + (r[0] & r[1]), CMAX);
      if (m_pos == m_len) begin
        if (was_busy) m_lost = sat(m_lost + 1, LMAX);
        else begin fq.push_back(m_ca); fq.push_back(m_cb); fq.push_back(m_cc); end
        if (run && cfg != 0) begin
          m_len = cfg; m_pos = 0; m_ca = 0; m_cb = 0; m_cc = 0;
        end else m_active = 1'b0;
      end else if (!run) m_active = 1'b0;
    end
    m_prev = td;
  endtask

  task automatic step();
    if (tvalid && tready) got.push_back(tdata);
    if (tvalid4 && tready) got4.push_back(tdata4);
    @(posedge clk);
    if (!aresetn) model_reset();
    else model_step();
    #1;
    check("model_tvalid", tvalid, fq.size() != 0);
    if (fq.size() != 0) begin
      check("model_tdata", tdata, fq[0]);
      check("model_tlast", tlast, fq.size() == 1);
    end
    check("model_sts_lost", lost, m_lost);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    check("rst_sts_lost", lost, 0);
    model_reset();
    step();
    step();
    aresetn = 1'b1;
    got.delete();
    got4.delete();
  endtask

  task automatic idle(input int n);
    run = 1'b0;
    td  = 2'b00;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_frame(input string name, input longint a, input longint b, input longint c);
    check({name, "_words"}, got.size(), 3);
    if (got.size() == 3) begin
      check({name, "_a"}, got[0], a);
      check({name, "_b"}, got[1], b);
      check({name, "_c"}, got[2], c);
    end
  endtask

  typedef struct {
    logic [1:0]  td;
    logic        run;
    logic [31:0] cfg;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        el;
  } vec_t;

  vec_t tbl[24];

  initial begin
    for (int i = 0; i < 24; i++) begin
      tbl[i].td = 2'b00; tbl[i].run = 1'b1; tbl[i].cfg = 32'd10; tbl[i].rdy = 1'b1;
      tbl[i].ev = 1'b0; tbl[i].ed = '0; tbl[i].el = 1'b0;
    end
    tbl[2].td = 2'b01;
    tbl[4].td = 2'b11;
    tbl[6].td = 2'b01;
    tbl[10].ev = 1'b1; tbl[10].ed = 32'd3;
    tbl[11].ev = 1'b1; tbl[11].ed = 32'd1;
    tbl[12].ev = 1'b1; tbl[12].ed = 32'd1; tbl[12].el = 1'b1;
    tbl[20].ev = 1'b1; tbl[20].ed = 32'd0;
    tbl[21].ev = 1'b1; tbl[21].ed = 32'd0;
    tbl[22].ev = 1'b1; tbl[22].ed = 32'd0; tbl[22].el = 1'b1;

    #2;
    do_reset();

    // Directed frame {3,1,1} followed by an empty frame.
    for (int i = 0; i < 24; i++) begin
      td = tbl[i].td; run = tbl[i].run; cfg = tbl[i].cfg; tready = tbl[i].rdy;
      step();
      check("tbl_tvalid", tvalid, tbl[i].ev);
      if (tbl[i].ev) begin
        check("tbl_tdata", tdata, tbl[i].ed);
        check("tbl_tlast", tlast, tbl[i].el);
      end
    end
    idle(8);

    // Level held high for the whole gate: one edge.
    got.delete();
    run = 1'b1; cfg = 32'd10; td = 2'b00; step();
    td = 2'b01;
    for (int i = 0; i < 10; i++) step();
    idle(6);
    check_frame("held_high", 1, 0, 0);

    // A toggling every cycle, gate of 8.
    got.delete();
    run = 1'b1; cfg = 32'd8; td = 2'b00; step();
    for (int i = 0; i < 8; i++) begin
      td = (i % 2 == 0) ? 2'b01 : 2'b00;
      step();
    end
    idle(6);
    check_frame("toggle", 4, 0, 0);

    // Back-pressure: first frame held, later terminals counted as lost.
    do_reset();
    run = 1'b1; cfg = 32'd4; td = 2'b00; tready = 1'b0; step();
    for (int i = 0; i < 20; i++) begin
      td = (i % 2 == 0) ? 2'b01 : 2'b00;
      step();
      if (i >= 4) begin
        check("stall_tvalid", tvalid, 1);
        check("stall_tdata", tdata, 2);
        check("stall_tlast", tlast, 0);
      end
    end
    check("stall_lost", lost, 4);
    tready = 1'b1;
    idle(6);
    check_frame("stall", 2, 0, 0);
    check("stall_lost_after", lost, 4);

    // Abort mid-gate, then a clean gate.
    got.delete();
    run = 1'b1; cfg = 32'd10; td = 2'b00; step();
    for (int i = 1; i <= 4; i++) begin
      td = (i == 2) ? 2'b01 : 2'b00;
      step();
    end
    idle(16);
    check("abort_no_words", got.size(), 0);
    check("abort_tvalid", tvalid, 0);
    run = 1'b1; cfg = 32'd10; td = 2'b00; step();
    for (int i = 1; i <= 10; i++) begin
      td = (i == 3) ? 2'b01 : 2'b00;
      step();
    end
    idle(6);
    check_frame("after_abort", 1, 0, 0);

    // Narrow instance: longest gate of 15 cycles with A toggling.
    do_reset();
    run = 1'b1; cfg = 32'd15; td = 2'b00; step();
    for (int i = 0; i < 15; i++) begin
      td = (i % 2 == 0) ? 2'b01 : 2'b00;
      step();
    end
    idle(6);
    check("w4_words", got4.size(), 3);
    if (got4.size() == 3) begin
      check("w4_a", got4[0], 8);
      check("w4_b", got4[1], 0);
      check("w4_c", got4[2], 0);
    end

    // Reset after word 0, then a fresh frame from word 0.
    do_reset();
    run = 1'b1; cfg = 32'd4; td = 2'b00; step();
    td = 2'b01; step();
    td = 2'b00; step(); step(); step();
    check("midrst_tvalid_pre", tvalid, 1);
    run = 1'b0; tready = 1'b1; step();
    check("midrst_word0_sent", got.size(), 1);
    do_reset();
    run = 1'b1; cfg = 32'd4; td = 2'b00; step();
    td = 2'b11; step();
    td = 2'b00; step();
    td = 2'b01; step();
    td = 2'b00; step();
    idle(6);
    check_frame("post_reset", 2, 1, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      td     = 2'($urandom);
      run    = ($urandom_range(0, 99) < 96);
      cfg    = ($urandom_range(0, 19) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      tready = ($urandom_range(0, 3) != 0);
      step();
    end
    tready = 1'b1;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
